regfile_wb_arbiter: RTL and testbench

- Write-back initiator for the 32x64 four-read/two-write register file.
- Collects register write requests from NUM_SRC producers (execution units/cores) into per-source buffers.
- Each cycle, arbitrates up to two non-conflicting writes by fixed priority and drives the register file's two write ports.
- Exports a pending-write mask so issue logic can detect read-after-write hazards.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/wba_src_fifo.sv | 88 ++++++++
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and write-back request type
// Purpose: register file geometry, the write-back request record and an
//          address-to-one-hot decode helper used for hazard masks.
package regfile_pkg;

  localparam int               REG_COUNT = 32;
  localparam int               REG_AW    = 5;
  localparam int               REG_DW    = 64;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  function automatic logic [REG_COUNT-1:0] reg_decode(input logic [REG_AW-1:0] a);
    logic [REG_COUNT-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wba_src_fifo.sv
// rtl/wba_src_fifo.sv - per-source write-back request buffer
// Purpose: DEPTH-entry FIFO of wb_req_t with registered full/empty flags and
//          a one-hot mask of the destination registers it currently holds.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_push          enqueue i_push_data (caller guarantees not full)
//   i_push_data     request to enqueue
//   i_pop           dequeue the head (caller guarantees not empty)
//   o_head          current head entry
//   o_full/o_empty  registered occupancy flags
//   o_addr_mask     OR of decoded addresses of all valid entries
module wba_src_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  wb_req_t              i_push_data,
  input  logic                 i_pop,
  output wb_req_t              o_head,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [REG_COUNT-1:0] o_addr_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic [PW:0]      w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers are PW bits wide and DEPTH is a power of two, so +1 wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_vld   <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (PW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      // Push and pop never hit the same slot: pop needs an entry, push needs room.
      if (i_pop) begin
        r_rd        <= r_rd + 1'b1;
        r_vld[r_rd] <= 1'b0;
      end
      if (i_push) begin
        r_wr        <= r_wr + 1'b1;
        r_vld[r_wr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_push_data;
  end

  always_comb begin
    o_addr_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) o_addr_mask = o_addr_mask | reg_decode(r_mem[i].addr);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - dual-port register file write-back arbiter
// Purpose: buffers register writes from NUM_SRC producers and issues up to two
//          non-conflicting writes per cycle to the register file write ports.
// Optional feature: define WBA_AGING_EN to promote heads that waited AGE_LIMIT cycles.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   req_valid/req_addr/req_data  per-source request channels (source 0 highest priority)
//   req_ready                    per-source buffer not full
//   write_port_1/2, write_data_1/2  registered write ports (address 0 = no write)
//   pending_mask                 registers with a buffered or in-flight write
//   idle                         nothing buffered and both ports idle
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DEPTH     = 2,
  parameter int AGE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*REG_AW-1:0] req_addr,
  input  logic [NUM_SRC*REG_DW-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic [REG_AW-1:0]         write_port_1,
  output logic [REG_DW-1:0]         write_data_1,
  output logic [REG_AW-1:0]         write_port_2,
  output logic [REG_DW-1:0]         write_data_2,
  output logic [REG_COUNT-1:0]      pending_mask,
  output logic                      idle
);

  wb_req_t                w_head [NUM_SRC];
  logic [REG_COUNT-1:0]   w_src_mask [NUM_SRC];
  logic [NUM_SRC-1:0]     w_full;
  logic [NUM_SRC-1:0]     w_empty;
  logic [NUM_SRC-1:0]     w_push;
  logic [NUM_SRC-1:0]     w_gnt;
  logic [NUM_SRC-1:0]     w_aged;
  logic                   w_g1_vld;
  logic                   w_g2_vld;
  wb_req_t                w_g1;
  wb_req_t                w_g2;
  logic [REG_AW-1:0]      r_wp1;
  logic [REG_AW-1:0]      r_wp2;
  logic [REG_DW-1:0]      r_wd1;
  logic [REG_DW-1:0]      r_wd2;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    wb_req_t w_in;
    assign w_in.addr = req_addr[s*REG_AW +: REG_AW];
    assign w_in.data = req_data[s*REG_DW +: REG_DW];
    // Writes to register 0 complete the handshake but are discarded here.
    assign w_push[s] = req_valid[s] & ~w_full[s] & (w_in.addr != REG_ZERO);

    wba_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push[s]),
      .i_push_data (w_in),
      .i_pop       (w_gnt[s]),
      .o_head      (w_head[s]),
      .o_full      (w_full[s]),
      .o_empty     (w_empty[s]),
      .o_addr_mask (w_src_mask[s])
    );
  end

  assign req_ready = ~w_full;

`ifdef WBA_AGING_EN
  localparam int AGW = $clog2(AGE_LIMIT + 1);
  logic [AGW-1:0] r_age [NUM_SRC];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SRC; s++) r_age[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (w_empty[s] || w_gnt[s])            r_age[s] <= '0;
        else if (r_age[s] != AGW'(AGE_LIMIT))  r_age[s] <= r_age[s] + 1'b1;
      end
    end
  end

  always_comb begin
    w_aged = '0;
    for (int s = 0; s < NUM_SRC; s++) w_aged[s] = (r_age[s] >= AGW'(AGE_LIMIT));
  end
`else
  assign w_aged = '0;
`endif

  // Pass 0 visits aged heads, pass 1 the rest; each in index order. A head
  // whose address matches the port-1 grant is skipped and the walk continues.
  always_comb begin
    w_gnt    = '0;
    w_g1_vld = 1'b0;
    w_g2_vld = 1'b0;
    w_g1     = '0;
    w_g2     = '0;
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (!w_empty[s] && (w_aged[s] == (p == 0))) begin
          if (!w_g1_vld) begin
            w_g1_vld = 1'b1;
            w_g1     = w_head[s];
            w_gnt[s] = 1'b1;
          end else if (!w_g2_vld && (w_head[s].addr != w_g1.addr)) begin
            w_g2_vld = 1'b1;
            w_g2     = w_head[s];
            w_gnt[s] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp1 <= REG_ZERO;
      r_wp2 <= REG_ZERO;
      r_wd1 <= '0;
      r_wd2 <= '0;
    end else begin
      r_wp1 <= w_g1_vld ? w_g1.addr : REG_ZERO;
      r_wd1 <= w_g1_vld ? w_g1.data : '0;
      r_wp2 <= w_g2_vld ? w_g2.addr : REG_ZERO;
      r_wd2 <= w_g2_vld ? w_g2.data : '0;
    end
  end

  always_comb begin
    pending_mask = reg_decode(r_wp1) | reg_decode(r_wp2);
    for (int s = 0; s < NUM_SRC; s++) pending_mask = pending_mask | w_src_mask[s];
    pending_mask[0] = 1'b0;
  end

  assign write_port_1 = r_wp1;
  assign write_data_1 = r_wd1;
  assign write_port_2 = r_wp2;
  assign write_data_2 = r_wd2;
  assign idle         = (&w_empty) && (r_wp1 == REG_ZERO) && (r_wp2 == REG_ZERO);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [255:0] req_data;
  logic [3:0]   req_ready;
  logic [4:0]   write_port_1;
  logic [63:0]  write_data_1;
  logic [4:0]   write_port_2;
  logic [63:0]  write_data_2;
  logic [31:0]  pending_mask;
  logic         idle;

  int n_total = 0;
  int n_pass  = 0;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .write_port_1 (write_port_1),
    .write_data_1 (write_data_1),
    .write_port_2 (write_port_2),
    .write_data_2 (write_data_2),
    .pending_mask (pending_mask),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int s, input logic [4:0] a, input logic [63:0] d);
    req_addr[5*s +: 5]  = a;
    req_data[64*s +: 64] = d;
    req_valid[s]         = 1'b1;
  endtask

  // Two ports must never carry the same non-zero register.
  always @(negedge clk) begin
    if (!reset)
      check("port_dup", 64'((write_port_1 == write_port_2) && (write_port_1 != 5'd0)), 64'd0);
  end

  // Leaves src0/src1 streaming r1/r2 and src3 holding two entries plus a stalled r12.
  task automatic fill_src3();
    set_req(0, 5'd1, 64'h11);
    set_req(1, 5'd2, 64'h22);
    set_req(3, 5'd10, 64'h100);
    tick();                                   // E0
    check("bp_ready_e0", 64'(req_ready[3]), 64'd1);
    check("bp_mask_e0", 64'(pending_mask), 64'h0000_0406);
    set_req(3, 5'd11, 64'h101);
    tick();                                   // E1
    check("bp_ready_e1", 64'(req_ready[3]), 64'd0);
    check("bp_p1_e1", 64'(write_port_1), 64'd1);
    check("bp_p2_e1", 64'(write_port_2), 64'd2);
    set_req(3, 5'd12, 64'h102);
    tick();                                   // E2
    check("bp_ready_e2", 64'(req_ready[3]), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    tick();
    check("rst_p1", 64'(write_port_1), 64'd0);
    check("rst_p2", 64'(write_port_2), 64'd0);
    check("rst_mask", 64'(pending_mask), 64'd0);
    check("rst_ready", 64'(req_ready), 64'hF);
    check("rst_idle", 64'(idle), 64'd1);
    reset = 1'b0;
    tick();

    // Single request from src2.
    set_req(2, 5'd5, 64'hDEAD_BEEF);
    tick();                                   // E0
    req_valid = '0;
    check("single_mask_e0", 64'(pending_mask), 64'h20);
    check("single_p1_e0", 64'(write_port_1), 64'd0);
    check("single_idle_e0", 64'(idle), 64'd0);
    tick();                                   // E1
    check("single_p1", 64'(write_port_1), 64'd5);
    check("single_d1", write_data_1, 64'hDEAD_BEEF);
    check("single_p2", 64'(write_port_2), 64'd0);
    check("single_mask_e1", 64'(pending_mask), 64'h20);
    tick();                                   // E2
    check("single_mask_e2", 64'(pending_mask), 64'd0);
    check("single_idle_e2", 64'(idle), 64'd1);

    // Dual grant.
    set_req(0, 5'd3, 64'h33);
    set_req(3, 5'd7, 64'h77);
    tick();
    req_valid = '0;
    tick();
    check("dual_p1", 64'(write_port_1), 64'd3);
    check("dual_d1", write_data_1, 64'h33);
    check("dual_p2", 64'(write_port_2), 64'd7);
    check("dual_d2", write_data_2, 64'h77);
    tick();
    check("dual_idle", 64'(idle), 64'd1);

    // Same-register conflict.
    set_req(1, 5'd9, 64'hA);
    set_req(2, 5'd9, 64'hB);
    tick();
    req_valid = '0;
    check("conf_mask", 64'(pending_mask), 64'h200);
    tick();
    check("conf_c1_p1", 64'(write_port_1), 64'd9);
    check("conf_c1_d1", write_data_1, 64'hA);
    check("conf_c1_p2", 64'(write_port_2), 64'd0);
    tick();
    check("conf_c2_p1", 64'(write_port_1), 64'd9);
    check("conf_c2_d1", write_data_1, 64'hB);
    check("conf_c2_p2", 64'(write_port_2), 64'd0);
    tick();
    check("conf_idle", 64'(idle), 64'd1);

    // Backpressure on starved src3.
    fill_src3();
    req_valid = 4'b1000;
    tick();                                   // E3
    check("bp_ready_e3", 64'(req_ready[3]), 64'd0);
    check("bp_p1_e3", 64'(write_port_1), 64'd1);
    tick();                                   // E4
    check("bp_ready_e4", 64'(req_ready[3]), 64'd1);
    check("bp_p1_e4", 64'(write_port_1), 64'd10);
    check("bp_d1_e4", write_data_1, 64'h100);
    check("bp_p2_e4", 64'(write_port_2), 64'd0);
    tick();                                   // E5: r12 accepted
    req_valid = '0;
    check("bp_p1_e5", 64'(write_port_1), 64'd11);
    tick();
    check("bp_p1_e6", 64'(write_port_1), 64'd12);
    check("bp_d1_e6", write_data_1, 64'h102);
    tick();
    check("bp_idle", 64'(idle), 64'd1);

    // Address 0 is accepted and dropped.
    set_req(3, 5'd0, 64'h5555);
    tick();
    req_valid = '0;
    check("a0_ready", 64'(req_ready), 64'hF);
    check("a0_mask", 64'(pending_mask), 64'd0);
    check("a0_idle", 64'(idle), 64'd1);
    tick();
    check("a0_p1", 64'(write_port_1), 64'd0);
    check("a0_p2", 64'(write_port_2), 64'd0);

    // Reset mid-stream with entries buffered and ports busy.
    fill_src3();
    reset = 1'b1;
    #1;
    check("mrst_p1", 64'(write_port_1), 64'd0);
    check("mrst_p2", 64'(write_port_2), 64'd0);
    check("mrst_mask", 64'(pending_mask), 64'd0);
    check("mrst_ready", 64'(req_ready), 64'hF);
    check("mrst_idle", 64'(idle), 64'd1);
    req_valid = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_after_p1", 64'(write_port_1), 64'd0);
      check("mrst_after_idle", 64'(idle), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
